// File: rtl/mem_stage.sv
// RV32I MEM stage: byte-addressable data memory plus the MEM/WB pipeline register.
// Loads are read combinationally from the array and sign/zero-extended into
// MEM/WB. Stores (byte/half/word) commit on the rising clock edge.
module mem_stage #(
   parameter int MEM_ADDR_BITS = 13
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        regwrite_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [1:0]  memtoreg_i,
   input  logic [31:0] pc_address_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic [2:0]  funct3_i,
   input  logic        ex_valid_i,
   output logic        regwrite_o,
   output logic [4:0]  rd_addr_o,
   output logic [1:0]  memtoreg_o,
   output logic [31:0] pc_address_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] mem_data_o,
   output logic        mem_valid_o
);

   localparam int DEPTH = 1 << MEM_ADDR_BITS;

   typedef struct packed {
      logic        regwrite;
      logic [4:0]  rd_addr;
      logic [1:0]  memtoreg;
      logic [31:0] pc_address;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic        mem_valid;
   } mem_wb_t;

   logic [31:0]              mem_q [DEPTH];
   logic [MEM_ADDR_BITS-1:0] word_idx;
   logic [1:0]               lane;
   logic [31:0]              rd_word;
   logic [7:0]               rd_byte;
   logic [15:0]              rd_half;
   logic [31:0]              load_data;
   logic [3:0]               byte_en;
   logic [31:0]              wr_data;
   logic                     store_en;
   logic                     addr_unused;
   mem_wb_t                  wb_d;
   mem_wb_t                  wb_q;

   // Upper address bits are deliberately dropped so accesses alias across the array.
   assign word_idx    = alu_result_i[MEM_ADDR_BITS+1:2];
   assign lane        = alu_result_i[1:0];
   assign addr_unused = ^alu_result_i[31:MEM_ADDR_BITS+2];
   assign rd_word     = mem_q[word_idx];
   assign store_en    = memwrite_i & ex_valid_i & ~stall_i & ~flush_i & ~rst_i;

   // Select the addressed byte/half and extend it according to funct3.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      rd_byte   = rd_word[7:0];
      load_data = rd_word;
      case (lane)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = alu_result_i[1] ? rd_word[31:16] : rd_word[15:0];
      case (funct3_i)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_data = {24'h0, rd_byte};
         3'b101:  load_data = {16'h0, rd_half};
         default: load_data = rd_word;
      endcase
   end

   // Build byte enables and lane-replicated write data for the store size.
   always_comb begin
      byte_en = 4'b1111;
      wr_data = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            byte_en = alu_result_i[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{store_data_i[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wr_data = store_data_i;
         end
      endcase
   end

   // Commit enabled byte lanes of a store; a same-cycle load still sees the old word.
   // NOTE: the data array has no reset branch; clearing thousands of words is not needed for correct operation.
   always_ff @(posedge clk_i) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Next MEM/WB contents when the register is loading.
   always_comb begin
      wb_d.regwrite   = regwrite_i & ex_valid_i;
      wb_d.rd_addr    = rd_addr_i;
      wb_d.memtoreg   = memtoreg_i;
      wb_d.pc_address = pc_address_i;
      wb_d.alu_result = alu_result_i;
      wb_d.mem_data   = memread_i ? load_data : 32'h0;
      wb_d.mem_valid  = ex_valid_i;
   end

   // MEM/WB register: reset and flush clear, stall holds, otherwise load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst_i) begin
         wb_q <= '0;
      end else if (flush_i) begin
         wb_q <= '0;
      end else if (!stall_i) begin
         wb_q <= wb_d;
      end
   end

   assign regwrite_o   = wb_q.regwrite;
   assign rd_addr_o    = wb_q.rd_addr;
   assign memtoreg_o   = wb_q.memtoreg;
   assign pc_address_o = wb_q.pc_address;
   assign alu_result_o = wb_q.alu_result;
   assign mem_data_o   = wb_q.mem_data;
   assign mem_valid_o  = wb_q.mem_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of load/store vectors with expected load data,
// a scoreboard queue of expected MEM/WB contents, and hand-written reset,
// stall, flush and asynchronous-reset sequences.
module tb_mem_stage;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;
   localparam logic [2:0] F_X  = 3'b111;
   localparam logic [2:0] F_Y  = 3'b011;

   typedef struct packed {
      logic        regwrite;
      logic [4:0]  rd_addr;
      logic [1:0]  memtoreg;
      logic [31:0] pc_address;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic        mem_valid;
   } out_t;

   typedef struct {
      logic        rd_en;
      logic        wr_en;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        valid;
      logic [31:0] exp_md;
      string       name;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        regwrite_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic [1:0]  memtoreg_i = '0;
   logic [31:0] pc_address_i = '0;
   logic [31:0] alu_result_i = '0;
   logic [31:0] store_data_i = '0;
   logic        memread_i = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic        ex_valid_i = 1'b0;
   logic        regwrite_o;
   logic [4:0]  rd_addr_o;
   logic [1:0]  memtoreg_o;
   logic [31:0] pc_address_o;
   logic [31:0] alu_result_o;
   logic [31:0] mem_data_o;
   logic        mem_valid_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   out_t sb[$];
   out_t last_exp = '0;
   vec_t vecs[$];

   mem_stage #(.MEM_ADDR_BITS(13)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .regwrite_i   (regwrite_i),
      .rd_addr_i    (rd_addr_i),
      .memtoreg_i   (memtoreg_i),
      .pc_address_i (pc_address_i),
      .alu_result_i (alu_result_i),
      .store_data_i (store_data_i),
      .memread_i    (memread_i),
      .memwrite_i   (memwrite_i),
      .funct3_i     (funct3_i),
      .ex_valid_i   (ex_valid_i),
      .regwrite_o   (regwrite_o),
      .rd_addr_o    (rd_addr_o),
      .memtoreg_o   (memtoreg_o),
      .pc_address_o (pc_address_o),
      .alu_result_o (alu_result_o),
      .mem_data_o   (mem_data_o),
      .mem_valid_o  (mem_valid_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", what, act, exp);
      end
   endtask

   task automatic compare(input string name, input out_t e);
      check({name, ".regwrite"},   32'(regwrite_o),   32'(e.regwrite));
      check({name, ".rd_addr"},    32'(rd_addr_o),    32'(e.rd_addr));
      check({name, ".memtoreg"},   32'(memtoreg_o),   32'(e.memtoreg));
      check({name, ".pc_address"}, pc_address_o,      e.pc_address);
      check({name, ".alu_result"}, alu_result_o,      e.alu_result);
      check({name, ".mem_data"},   mem_data_o,        e.mem_data);
      check({name, ".mem_valid"},  32'(mem_valid_o),  32'(e.mem_valid));
   endtask

   function automatic vec_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic valid, input logic [31:0] exp_md, input string name);
      vec_t v;
      v.rd_en = rd_en; v.wr_en = wr_en; v.f3 = f3; v.addr = addr;
      v.wdata = wdata; v.valid = valid; v.exp_md = exp_md; v.name = name;
      return v;
   endfunction

   // Drive one EX-stage transaction and push the MEM/WB contents it should produce.
   task automatic apply(input vec_t v, input int tag, input logic stall, input logic flush);
      out_t e;
      regwrite_i   = ~v.wr_en;
      rd_addr_i    = 5'(tag);
      memtoreg_i   = v.rd_en ? 2'd1 : 2'd0;
      pc_address_i = 32'h400 + 32'(tag) * 4;
      alu_result_i = v.addr;
      store_data_i = v.wdata;
      memread_i    = v.rd_en;
      memwrite_i   = v.wr_en;
      funct3_i     = v.f3;
      ex_valid_i   = v.valid;
      stall_i      = stall;
      flush_i      = flush;
      if (flush) begin
         e = '0;
      end else if (stall) begin
         e = last_exp;
      end else begin
         e.regwrite   = ~v.wr_en & v.valid;
         e.rd_addr    = 5'(tag);
         e.memtoreg   = v.rd_en ? 2'd1 : 2'd0;
         e.pc_address = 32'h400 + 32'(tag) * 4;
         e.alu_result = v.addr;
         e.mem_data   = v.rd_en ? v.exp_md : 32'h0;
         e.mem_valid  = v.valid;
      end
      sb.push_back(e);
   endtask

   // Advance one edge, then pop the scoreboard and compare.
   task automatic step(input string name);
      out_t e;
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got no expectation, required one", name);
      end else begin
         e = sb.pop_front();
         compare(name, e);
         last_exp = e;
      end
   endtask

   initial begin
      vecs.push_back(mk(0, 1, F_W,  32'h0,    32'h11223344, 1, 32'h0,        "sw0"));
      vecs.push_back(mk(0, 1, F_W,  32'h4,    32'haabbccdd, 1, 32'h0,        "sw4"));
      vecs.push_back(mk(1, 0, F_W,  32'h0,    32'h0,        1, 32'h11223344, "lw0"));
      vecs.push_back(mk(1, 0, F_W,  32'h4,    32'h0,        1, 32'haabbccdd, "lw4"));
      vecs.push_back(mk(0, 1, F_W,  32'h8,    32'h80817f01, 1, 32'h0,        "sw8"));
      vecs.push_back(mk(1, 0, F_B,  32'h8,    32'h0,        1, 32'h00000001, "lb8"));
      vecs.push_back(mk(1, 0, F_B,  32'hb,    32'h0,        1, 32'hffffff80, "lb11"));
      vecs.push_back(mk(1, 0, F_BU, 32'hb,    32'h0,        1, 32'h00000080, "lbu11"));
      vecs.push_back(mk(1, 0, F_H,  32'ha,    32'h0,        1, 32'hffff8081, "lh10"));
      vecs.push_back(mk(1, 0, F_HU, 32'ha,    32'h0,        1, 32'h00008081, "lhu10"));
      vecs.push_back(mk(1, 0, F_H,  32'h8,    32'h0,        1, 32'h00007f01, "lh8"));
      vecs.push_back(mk(1, 0, F_B,  32'h9,    32'h0,        1, 32'h0000007f, "lb9"));
      vecs.push_back(mk(0, 1, F_B,  32'h1,    32'h123456aa, 1, 32'h0,        "sb1"));
      vecs.push_back(mk(1, 0, F_W,  32'h0,    32'h0,        1, 32'h1122aa44, "lw0_sb"));
      vecs.push_back(mk(0, 1, F_H,  32'h2,    32'h5555beef, 1, 32'h0,        "sh2"));
      vecs.push_back(mk(1, 0, F_W,  32'h0,    32'h0,        1, 32'hbeefaa44, "lw0_sh"));
      vecs.push_back(mk(1, 0, F_H,  32'h3,    32'h0,        1, 32'hffffbeef, "lh3"));
      vecs.push_back(mk(0, 1, F_W,  32'h8000, 32'h12345678, 1, 32'h0,        "sw_alias"));
      vecs.push_back(mk(1, 0, F_W,  32'h0,    32'h0,        1, 32'h12345678, "lw0_alias"));
      vecs.push_back(mk(0, 1, F_X,  32'h10,   32'hcafef00d, 1, 32'h0,        "s111"));
      vecs.push_back(mk(1, 0, F_X,  32'h10,   32'h0,        1, 32'hcafef00d, "l111"));
      vecs.push_back(mk(1, 0, F_W,  32'h10,   32'h0,        1, 32'hcafef00d, "lw16"));
      vecs.push_back(mk(1, 0, F_Y,  32'h11,   32'h0,        1, 32'hcafef00d, "l011"));
      vecs.push_back(mk(0, 1, F_W,  32'hc,    32'h0badf00d, 1, 32'h0,        "sw12"));
      vecs.push_back(mk(0, 1, F_W,  32'hc,    32'hffffffff, 0, 32'h0,        "sw12_inv"));
      vecs.push_back(mk(1, 0, F_W,  32'hc,    32'h0,        1, 32'h0badf00d, "lw12"));
      vecs.push_back(mk(0, 1, F_W,  32'h14,   32'h01010101, 1, 32'h0,        "sw20"));
      vecs.push_back(mk(1, 1, F_W,  32'h14,   32'h02020202, 1, 32'h01010101, "ldst20"));
      vecs.push_back(mk(1, 0, F_W,  32'h14,   32'h0,        1, 32'h02020202, "lw20"));

      // Reset state and the first idle cycle after release.
      repeat (2) @(posedge clk_i);
      #1;
      compare("reset", '0);
      rst_i = 1'b0;
      apply(mk(0, 0, F_W, 32'h0, 32'h0, 0, 32'h0, "idle"), 0, 1'b0, 1'b0);
      step("idle");

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i + 1, 1'b0, 1'b0);
         step(vecs[i].name);
      end

      // Stall: outputs hold for two cycles and the store is suppressed.
      apply(mk(0, 1, F_W, 32'hc, 32'hdeadbeef, 1, 32'h0, "stall"), 40, 1'b1, 1'b0);
      step("stall1");
      apply(mk(0, 1, F_W, 32'hc, 32'hdeadbeef, 1, 32'h0, "stall"), 41, 1'b1, 1'b0);
      step("stall2");
      apply(mk(1, 0, F_W, 32'hc, 32'h0, 1, 32'h0badf00d, "lw12_stall"), 42, 1'b0, 1'b0);
      step("lw12_after_stall");

      // Flush: outputs clear and the store is suppressed.
      apply(mk(1, 1, F_W, 32'hc, 32'hdeadbeef, 1, 32'h0, "flush"), 43, 1'b0, 1'b1);
      step("flush");
      apply(mk(1, 0, F_W, 32'hc, 32'h0, 1, 32'h0badf00d, "lw12_flush"), 44, 1'b0, 1'b0);
      step("lw12_after_flush");

      // Asynchronous reset mid-cycle clears outputs without a clock edge; memory is kept.
      apply(mk(1, 0, F_W, 32'h4, 32'h0, 1, 32'haabbccdd, "lw4_pre"), 45, 1'b0, 1'b0);
      step("lw4_pre_rst");
      #2;
      rst_i = 1'b1;
      #1;
      compare("async_rst", '0);
      last_exp = '0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      apply(mk(1, 0, F_W, 32'h0, 32'h0, 1, 32'h12345678, "lw0_post"), 46, 1'b0, 1'b0);
      step("lw0_post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
